regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the pipelined RISC-V core. It generalises the single-write, two-read register file in four ways:
- configurable width, depth and read-port count;
- two write ports with a fixed priority;
- optional write-to-read bypass;
- a per-register busy scoreboard for outstanding long-latency producers (loads, multi-cycle ops).

It sits in the decode stage. The hazard unit consumes the `rd_busy` outputs.

## Interface
- `XLEN`, 32, data width in bits
- `NREGS`, 32, number of architectural registers (power of two, ≥ 2); `AW = $clog2(NREGS)`
- `NRD`, 2, number of read ports (1..4)
- `BYPASS`, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see registered state only
- `INIT_IDX`, 9, register preloaded at reset (must be nonzero and < `NREGS`)
- `INIT_VAL`, 412, value loaded into `INIT_IDX` at reset

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `rd_addr`  in  `NRD*AW`  read addresses; port i is at `[i*AW +: AW]`
- `rd_data`  out  `NRD*XLEN`  read data; port i is at `[i*XLEN +: XLEN]`
- `rd_busy`  out  `NRD`  scoreboard bit for each read address
- `wa_we`  in  1  write port A enable (ALU writeback)
- `wa_addr`  in  `AW`  write port A address
- `wa_data`  in  `XLEN`  write port A data
- `wb_we`  in  1  write port B enable (load/long-latency writeback)
- `wb_addr`  in  `AW`  write port B address
- `wb_data`  in  `XLEN`  write port B data
- `sb_set`  in  1  mark a destination busy (issue of a long-latency op)
- `sb_addr`  in  `AW`  register to mark busy

## Operation
**Storage and reset**
- Storage is `NREGS × XLEN` flops plus an `NREGS`-bit busy vector.
- Reset (rst=1 at a clk edge) loads every register with 0, except `INIT_IDX`, which gets `INIT_VAL`.
- Reset clears all busy bits.
- All writes and `sb_set` requests in a reset cycle are discarded.

**Register 0**
- Reads of register 0 always return 0 with busy 0.
- Writes to register 0 are ignored.
- `sb_set` to register 0 is ignored.

**Writes**
- A write updates the register at the clk edge.
- If port A and port B target the same address in the same cycle, port B wins.

**Reads**
- Each read port is combinational from `rd_addr`.
- While rst=1, `rd_data` and `rd_busy` are forced to 0.
- With `BYPASS=1`, if `rd_addr` matches an enabled write address in the same cycle:
  - `rd_data` returns that write data, with port B taking priority;
  - `rd_busy` for that port is 0.
- With `BYPASS=0`, reads return the registered value, and `rd_busy` is the registered bit.

**Scoreboard**
- `sb_set` sets `busy[sb_addr]` at the edge.
- Any enabled write to an address clears its busy bit at the edge.
- If `sb_set` and a write hit the same address in the same cycle, set wins: the register takes the write data and stays busy, because a new producer has been issued.
- A set to an already-busy register is legal and leaves it busy.

## Timing
- Write to readable via registered path: 1 cycle (visible the cycle after the enable edge).
- Write to readable via bypass: 0 cycles.
- Scoreboard set to `rd_busy`=1: 1 cycle. The `rd_busy` path is never bypassed for `sb_set`.
- Scoreboard clear by write: `rd_busy` goes to 0 in the write cycle when `BYPASS=1`, otherwise on the next cycle.
- Reset values:
  - `rd_data` is 0 during reset;
  - after reset, `rd_data` shows the reset contents (all 0, with `INIT_VAL` at `INIT_IDX`);
  - `rd_busy` is 0.
- Reset asserted mid-operation overrides pending writes and sets in that cycle. There is no multi-cycle clear sequence.
- No stall or backpressure. Every request completes in the cycle presented.

## Test plan
- **Reset preload:** assert rst 1 cycle, then read regs 0, 5, 9 on 3 ports (`NRD=3`) → 0, 0, 412 (`INIT_VAL`); all `rd_busy`=0; with rst held, all outputs read 0.
- **Write collision and bypass:** `wa` writes x7←0x1111 and `wb` writes x7←0x2222 in the same cycle, while port 0 reads x7 → same-cycle `rd_data`=0x2222 (`BYPASS=1`); next cycle x7 reads 0x2222. With `BYPASS=0`, same cycle returns the old value 0.
- **x0 protection:** write x0←0xDEADBEEF on both ports plus `sb_set` x0 → x0 reads 0, `rd_busy`=0 on every following cycle.
- **Scoreboard lifecycle:** `sb_set` x12 in cycle n → `rd_busy`=1 for x12 from n+1; `wb` writes x12←0xABCD in cycle n+4 → busy 0 and data 0xABCD in n+4 (bypass) and n+5.
- **Set/clear race:** `sb_set` x3 and `wa` write x3←0x55 in the same cycle → x3 = 0x55 and `rd_busy`=1 next cycle.
- **Mid-operation reset:** x9 holds 0x77 and x4 is busy; assert rst together with a `wa` write x4←0x99 → next cycle x9=412, x4=0, all busy 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file for the decode stage.
// Two priority write ports, optional bypass, and a busy scoreboard.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int INIT_IDX = 9,
  parameter int INIT_VAL = 412,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wa_we,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wb_we,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr
);

  localparam logic [AW-1:0]   INIT_A = AW'(INIT_IDX);
  localparam logic [XLEN-1:0] INIT_V = XLEN'(INIT_VAL);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wa_ok;
  logic wb_ok;
  logic sb_ok;

  assign wa_ok = wa_we && (wa_addr != '0);
  assign wb_ok = wb_we && (wb_addr != '0);
  assign sb_ok = sb_set && (sb_addr != '0);

  // Port B is applied after A so it wins a same-address collision;
  // sb_set comes last because a freshly issued producer outranks the write.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wa_ok) begin
      regs_d[wa_addr] = wa_data;
      busy_d[wa_addr] = 1'b0;
    end
    if (wb_ok) begin
      regs_d[wb_addr] = wb_data;
      busy_d[wb_addr] = 1'b0;
    end
    if (sb_ok) begin
      busy_d[sb_addr] = 1'b1;
    end
    if (rst) begin
      regs_d = '{default: '0};
      regs_d[INIT_A] = INIT_V;
      busy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    busy_q <= busy_d;
  end

  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;
    rd_data = '0;
    rd_busy = '0;
    a = '0;
    d = '0;
    b = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      a = rd_addr[i*AW +: AW];
      d = regs_q[a];
      b = busy_q[a];
      if (BYPASS != 0) begin
        if (wa_ok && (wa_addr == a)) begin
          d = wa_data;
          b = 1'b0;
        end
        if (wb_ok && (wb_addr == a)) begin
          d = wb_data;
          b = 1'b0;
        end
      end
      if ((a == '0) || rst) begin
        d = '0;
        b = 1'b0;
      end
      rd_data[i*XLEN +: XLEN] = d;
      rd_busy[i] = b;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing and a
// non-bypassing instance share stimulus, three read ports each.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 3;

  logic              clk;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] b_data;
  logic [NRD-1:0]    b_busy;
  logic [NRD*XLEN-1:0] n_data;
  logic [NRD-1:0]    n_busy;
  logic              wa_we;
  logic [AW-1:0]     wa_addr;
  logic [XLEN-1:0]   wa_data;
  logic              wb_we;
  logic [AW-1:0]     wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(3), .BYPASS(1),
               .INIT_IDX(9), .INIT_VAL(412)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr),
    .rd_data(b_data), .rd_busy(b_busy),
    .wa_we(wa_we), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(3), .BYPASS(0),
               .INIT_IDX(9), .INIT_VAL(412)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr),
    .rd_data(n_data), .rd_busy(n_busy),
    .wa_we(wa_we), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total;
  int   passed;

  function automatic logic [31:0] act_d(int sel, int p);
    return (sel == 0) ? b_data[p*XLEN +: XLEN] : n_data[p*XLEN +: XLEN];
  endfunction

  function automatic logic act_b(int sel, int p);
    return (sel == 0) ? b_busy[p] : n_busy[p];
  endfunction

  task automatic push(string n, int sel, int p, logic [31:0] d, logic b);
    exp_t x;
    x.name = n; x.sel = sel; x.port = p; x.data = d; x.busy = b;
    q.push_back(x);
  endtask

  task automatic push2(string n, int p, logic [31:0] d, logic b);
    push(n, 0, p, d, b);
    push(n, 1, p, d, b);
  endtask

  task automatic idle();
    wa_we = 0; wa_addr = '0; wa_data = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0;
    sb_set = 0; sb_addr = '0;
  endtask

  task automatic reads(int a0, int a1, int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); reads(0, 5, 9);
    for (int p = 0; p < 3; p++) push2("rst_held", p, 32'd0, 1'b0);
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); total++;
      if (act_d(e.sel, e.port) !== e.data || act_b(e.sel, e.port) !== e.busy)
        $display("FAIL %s dut%0d p%0d: got %h/%b want %h/%b", e.name, e.sel,
                 e.port, act_d(e.sel, e.port), act_b(e.sel, e.port), e.data, e.busy);
      else passed++;
    end
    tick(); rst = 0;
    push2("preload", 0, 32'd0, 1'b0);
    push2("preload", 1, 32'd0, 1'b0);
    push2("preload", 2, 32'd412, 1'b0);
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); total++;
      if (act_d(e.sel, e.port) !== e.data || act_b(e.sel, e.port) !== e.busy)
        $display("FAIL %s dut%0d p%0d: got %h/%b want %h/%b", e.name, e.sel,
                 e.port, act_d(e.sel, e.port), act_b(e.sel, e.port), e.data, e.busy);
      else passed++;
    end
  endtask

  task automatic test_collision();
    tick();
    wa_we = 1; wa_addr = 7; wa_data = 32'h1111;
    wb_we = 1; wb_addr = 7; wb_data = 32'h2222;
    reads(7, 9, 0);
    push("coll_bypass", 0, 0, 32'h2222, 1'b0);
    push("coll_nobyp", 1, 0, 32'h0, 1'b0);
    push2("coll_other", 1, 32'd412, 1'b0);
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); total++;
      if (act_d(e.sel, e.port) !== e.data || act_b(e.sel, e.port) !== e.busy)
        $display("FAIL %s dut%0d p%0d: got %h/%b want %h/%b", e.name, e.sel,
                 e.port, act_d(e.sel, e.port), act_b(e.sel, e.port), e.data, e.busy);
      else passed++;
    end
    tick(); idle();
    push2("coll_after", 0, 32'h2222, 1'b0);
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); total++;
      if (act_d(e.sel, e.port) !== e.data || act_b(e.sel, e.port) !== e.busy)
        $display("FAIL %s dut%0d p%0d: got %h/%b want %h/%b", e.name, e.sel,
                 e.port, act_d(e.sel, e.port), act_b(e.sel, e.port), e.data, e.busy);
      else passed++;
    end
  endtask

  task automatic test_x0();
    tick();
    wa_we = 1; wa_addr = 0; wa_data = 32'hDEADBEEF;
    wb_we = 1; wb_addr = 0; wb_data = 32'hDEADBEEF;
    sb_set = 1; sb_addr = 0;
    reads(0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 3; p++) push2("x0", p, 32'd0, 1'b0);
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front(); total++;
        if (act_d(e.sel, e.port) !== e.data || act_b(e.sel, e.port) !== e.busy)
          $display("FAIL %s dut%0d p%0d: got %h/%b want %h/%b", e.name, e.sel,
                   e.port, act_d(e.sel, e.port), act_b(e.sel, e.port), e.data, e.busy);
        else passed++;
      end
      tick(); idle();
    end
  endtask

  task automatic test_scoreboard();
    sb_set = 1; sb_addr = 12;
    reads(12, 0, 9);
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) push2("sb_set_cyc", 0, 32'd0, 1'b0);
      else if (c < 4) push2("sb_busy", 0, 32'd0, 1'b1);
      else if (c == 4) begin
        wb_we = 1; wb_addr = 12; wb_data = 32'hABCD;
        push("sb_clr_byp", 0, 0, 32'hABCD, 1'b0);
        push("sb_clr_nob", 1, 0, 32'h0, 1'b1);
      end else push2("sb_clr_after", 0, 32'hABCD, 1'b0);
      push2("sb_other", 2, 32'd412, 1'b0);
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front(); total++;
        if (act_d(e.sel, e.port) !== e.data || act_b(e.sel, e.port) !== e.busy)
          $display("FAIL %s dut%0d p%0d: got %h/%b want %h/%b", e.name, e.sel,
                   e.port, act_d(e.sel, e.port), act_b(e.sel, e.port), e.data, e.busy);
        else passed++;
      end
      tick(); idle();
    end
  endtask

  task automatic test_race();
    sb_set = 1; sb_addr = 3;
    wa_we = 1; wa_addr = 3; wa_data = 32'h55;
    reads(0, 3, 12);
    push("race_byp", 0, 1, 32'h55, 1'b0);
    push("race_nob", 1, 1, 32'h0, 1'b0);
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); total++;
      if (act_d(e.sel, e.port) !== e.data || act_b(e.sel, e.port) !== e.busy)
        $display("FAIL %s dut%0d p%0d: got %h/%b want %h/%b", e.name, e.sel,
                 e.port, act_d(e.sel, e.port), act_b(e.sel, e.port), e.data, e.busy);
      else passed++;
    end
    tick(); idle();
    push2("race_after", 1, 32'h55, 1'b1);
    push2("race_x12", 2, 32'hABCD, 1'b0);
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); total++;
      if (act_d(e.sel, e.port) !== e.data || act_b(e.sel, e.port) !== e.busy)
        $display("FAIL %s dut%0d p%0d: got %h/%b want %h/%b", e.name, e.sel,
                 e.port, act_d(e.sel, e.port), act_b(e.sel, e.port), e.data, e.busy);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    logic [31:0] v;
    prev = 32'd0;
    tick();
    reads(5, 5, 9);
    for (int c = 0; c < 6; c++) begin
      v = $urandom;
      idle();
      if (c[0]) begin wb_we = 1; wb_addr = 5; wb_data = v; end
      else begin wa_we = 1; wa_addr = 5; wa_data = v; end
      push("b2b_byp", 0, 0, v, 1'b0);
      push("b2b_nob", 1, 1, prev, 1'b0);
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front(); total++;
        if (act_d(e.sel, e.port) !== e.data || act_b(e.sel, e.port) !== e.busy)
          $display("FAIL %s dut%0d p%0d: got %h/%b want %h/%b", e.name, e.sel,
                   e.port, act_d(e.sel, e.port), act_b(e.sel, e.port), e.data, e.busy);
        else passed++;
      end
      prev = v;
      tick();
    end
    idle();
  endtask

  task automatic test_midreset();
    wa_we = 1; wa_addr = 9; wa_data = 32'h77;
    sb_set = 1; sb_addr = 4;
    tick(); idle();
    reads(9, 4, 3);
    push2("mid_pre_x9", 0, 32'h77, 1'b0);
    push2("mid_pre_x4", 1, 32'h0, 1'b1);
    push2("mid_pre_x3", 2, 32'h55, 1'b1);
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); total++;
      if (act_d(e.sel, e.port) !== e.data || act_b(e.sel, e.port) !== e.busy)
        $display("FAIL %s dut%0d p%0d: got %h/%b want %h/%b", e.name, e.sel,
                 e.port, act_d(e.sel, e.port), act_b(e.sel, e.port), e.data, e.busy);
      else passed++;
    end
    tick();
    rst = 1; wa_we = 1; wa_addr = 4; wa_data = 32'h99;
    for (int p = 0; p < 3; p++) push2("mid_rst", p, 32'd0, 1'b0);
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); total++;
      if (act_d(e.sel, e.port) !== e.data || act_b(e.sel, e.port) !== e.busy)
        $display("FAIL %s dut%0d p%0d: got %h/%b want %h/%b", e.name, e.sel,
                 e.port, act_d(e.sel, e.port), act_b(e.sel, e.port), e.data, e.busy);
      else passed++;
    end
    tick(); rst = 0; idle();
    push2("mid_x9", 0, 32'd412, 1'b0);
    push2("mid_x4", 1, 32'd0, 1'b0);
    push2("mid_x3", 2, 32'd0, 1'b0);
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); total++;
      if (act_d(e.sel, e.port) !== e.data || act_b(e.sel, e.port) !== e.busy)
        $display("FAIL %s dut%0d p%0d: got %h/%b want %h/%b", e.name, e.sel,
                 e.port, act_d(e.sel, e.port), act_b(e.sel, e.port), e.data, e.busy);
      else passed++;
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1;
    idle();
    reads(0, 0, 0);
    test_reset();
    test_collision();
    test_x0();
    test_scoreboard();
    test_race();
    test_back_to_back();
    test_midreset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
